// File: rtl/id_stage_pipe_if.sv
// Handshake and data bundle around the decode stage: IF/ID side, EX hazard info,
// write-back port and the registered ID/EX bundle.
interface id_stage_pipe_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     inst;
  logic            flush;
  logic            ex_memread;
  logic [4:0]      ex_rd;
  logic            wb_we;
  logic [4:0]      wb_rd;
  logic [XLEN-1:0] wb_data;
  logic            out_valid;
  logic            out_ready;
  logic [6:0]      out_ctrl;
  logic [4:0]      out_rs1;
  logic [4:0]      out_rs2;
  logic [4:0]      out_rd;
  logic [XLEN-1:0] out_rdata1;
  logic [XLEN-1:0] out_rdata2;
  logic [XLEN-1:0] out_imm;

  modport master (
    output in_valid, inst, flush, ex_memread, ex_rd, wb_we, wb_rd, wb_data, out_ready,
    input  in_ready, out_valid, out_ctrl, out_rs1, out_rs2, out_rd,
           out_rdata1, out_rdata2, out_imm
  );

  modport slave (
    input  in_valid, inst, flush, ex_memread, ex_rd, wb_we, wb_rd, wb_data, out_ready,
    output in_ready, out_valid, out_ctrl, out_rs1, out_rs2, out_rd,
           out_rdata1, out_rdata2, out_imm
  );
endinterface

// File: rtl/id_stage_pipe.sv
// RV32I decode stage with internal register file, WB bypass, load-use stall,
// flush and a registered valid/ready ID/EX bundle.
module id_stage_pipe #(
  parameter int XLEN     = 32,
  parameter int NUM_REGS = 32
) (
  input  logic           clk,
  input  logic           rst,
  id_stage_pipe_if.slave io_bus
);
  localparam int AW = $clog2(NUM_REGS);

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  typedef struct packed {
    logic branch;
    logic memread;
    logic memtoreg;
    logic memwrite;
    logic alusrc;
    logic regwrite;
    logic illegal;
  } ctrl_t;

  function automatic logic in_range(input logic [4:0] r);
    return int'(r) < NUM_REGS;
  endfunction

  logic [XLEN-1:0]    r_regs [NUM_REGS];
  logic               r_valid;
  ctrl_t              r_ctrl;
  logic [4:0]         r_rs1, r_rs2, r_rd;
  logic [XLEN-1:0]    r_rdata1, r_rdata2, r_imm;

  logic [31:0]        w_inst;
  logic [6:0]         w_op;
  logic [4:0]         w_rs1, w_rs2, w_rd;
  ctrl_t              w_ctrl;
  logic               w_use_rs1, w_use_rs2;
  logic signed [31:0] w_imm32;
  logic [XLEN-1:0]    w_imm;
  logic [XLEN-1:0]    w_rdata1, w_rdata2;
  logic               w_hazard, w_in_ready, w_accept;

  assign w_inst = io_bus.inst;
  assign w_op   = w_inst[6:0];
  assign w_rs1  = w_inst[19:15];
  assign w_rs2  = w_inst[24:20];
  assign w_rd   = w_inst[11:7];
  assign w_imm  = XLEN'(w_imm32);

  always_comb begin
    w_ctrl    = '0;
    w_imm32   = '0;
    w_use_rs1 = 1'b1;
    w_use_rs2 = 1'b0;
    case (w_op)
      OP_R: begin
        w_ctrl.regwrite = 1'b1;
        w_use_rs2       = 1'b1;
      end
      OP_IMM: begin
        w_ctrl.alusrc   = 1'b1;
        w_ctrl.regwrite = 1'b1;
        w_imm32         = {{20{w_inst[31]}}, w_inst[31:20]};
      end
      OP_LOAD: begin
        w_ctrl.memread  = 1'b1;
        w_ctrl.memtoreg = 1'b1;
        w_ctrl.alusrc   = 1'b1;
        w_ctrl.regwrite = 1'b1;
        w_imm32         = {{20{w_inst[31]}}, w_inst[31:20]};
      end
      OP_STORE: begin
        w_ctrl.memwrite = 1'b1;
        w_ctrl.alusrc   = 1'b1;
        w_use_rs2       = 1'b1;
        w_imm32         = {{20{w_inst[31]}}, w_inst[31:25], w_inst[11:7]};
      end
      OP_BR: begin
        w_ctrl.branch = 1'b1;
        w_use_rs2     = 1'b1;
        w_imm32       = {{19{w_inst[31]}}, w_inst[31], w_inst[7], w_inst[30:25],
                         w_inst[11:8], 1'b0};
      end
      OP_JAL: begin
        w_ctrl.regwrite = 1'b1;
        w_ctrl.branch   = 1'b1;
        w_use_rs1       = 1'b0;
        w_imm32         = {{11{w_inst[31]}}, w_inst[31], w_inst[19:12], w_inst[20],
                           w_inst[30:21], 1'b0};
      end
      OP_JALR: begin
        w_ctrl.regwrite = 1'b1;
        w_ctrl.branch   = 1'b1;
        w_ctrl.alusrc   = 1'b1;
        w_imm32         = {{20{w_inst[31]}}, w_inst[31:20]};
      end
      OP_LUI, OP_AUIPC: begin
        w_ctrl.regwrite = 1'b1;
        w_ctrl.alusrc   = 1'b1;
        w_use_rs1       = 1'b0;
        w_imm32         = {w_inst[31:12], 12'b0};
      end
      default: w_ctrl.illegal = 1'b1;
    endcase
    // Only fields the instruction actually uses as register indices are range-checked.
    if ((w_use_rs1 && !in_range(w_rs1)) || (w_use_rs2 && !in_range(w_rs2)) ||
        (w_ctrl.regwrite && !in_range(w_rd))) begin
      w_ctrl.illegal  = 1'b1;
      w_ctrl.regwrite = 1'b0;
    end
  end

  always_comb begin
    w_rdata1 = '0;
    w_rdata2 = '0;
    if (w_rs1 != 5'd0 && in_range(w_rs1)) w_rdata1 = r_regs[w_rs1[AW-1:0]];
    if (w_rs2 != 5'd0 && in_range(w_rs2)) w_rdata2 = r_regs[w_rs2[AW-1:0]];
    if (io_bus.wb_we && w_rs1 != 5'd0 && w_rs1 == io_bus.wb_rd) w_rdata1 = io_bus.wb_data;
    if (io_bus.wb_we && w_rs2 != 5'd0 && w_rs2 == io_bus.wb_rd) w_rdata2 = io_bus.wb_data;
  end

  assign w_hazard = io_bus.ex_memread && io_bus.ex_rd != 5'd0 &&
                    ((w_use_rs1 && io_bus.ex_rd == w_rs1) ||
                     (w_use_rs2 && io_bus.ex_rd == w_rs2));
  assign w_in_ready = (!r_valid || io_bus.out_ready) && !w_hazard;
  assign w_accept   = io_bus.in_valid && w_in_ready;

  // Write-back is independent of the ID/EX slot, so it commits through stall, hold and flush.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else if (io_bus.wb_we && io_bus.wb_rd != 5'd0 && in_range(io_bus.wb_rd)) begin
      r_regs[io_bus.wb_rd[AW-1:0]] <= io_bus.wb_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid  <= 1'b0;
      r_ctrl   <= '0;
      r_rs1    <= '0;
      r_rs2    <= '0;
      r_rd     <= '0;
      r_rdata1 <= '0;
      r_rdata2 <= '0;
      r_imm    <= '0;
    end else if (io_bus.flush) begin
      r_valid <= 1'b0;
    end else if (w_accept) begin
      r_valid  <= 1'b1;
      r_ctrl   <= w_ctrl;
      r_rs1    <= w_rs1;
      r_rs2    <= w_rs2;
      r_rd     <= w_rd;
      r_rdata1 <= w_rdata1;
      r_rdata2 <= w_rdata2;
      r_imm    <= w_imm;
    end else if (io_bus.out_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign io_bus.in_ready   = w_in_ready;
  assign io_bus.out_valid  = r_valid;
  assign io_bus.out_ctrl   = r_ctrl;
  assign io_bus.out_rs1    = r_rs1;
  assign io_bus.out_rs2    = r_rs2;
  assign io_bus.out_rd     = r_rd;
  assign io_bus.out_rdata1 = r_rdata1;
  assign io_bus.out_rdata2 = r_rdata2;
  assign io_bus.out_imm    = r_imm;
endmodule

// File: tb/tb_id_stage_pipe.sv
// Directed bench for id_stage_pipe: a 32-register and a 16-register instance.
module tb_id_stage_pipe;
  logic clk = 1'b0;
  logic rst;
  int   n_chk  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  id_stage_pipe_if #(.XLEN(32)) b1 ();
  id_stage_pipe_if #(.XLEN(32)) b2 ();

  id_stage_pipe #(.XLEN(32), .NUM_REGS(32)) dut1 (.clk(clk), .rst(rst), .io_bus(b1));
  id_stage_pipe #(.XLEN(32), .NUM_REGS(16)) dut2 (.clk(clk), .rst(rst), .io_bus(b2));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    b1.in_valid = 0; b1.inst = 0; b1.flush = 0; b1.ex_memread = 0; b1.ex_rd = 0;
    b1.wb_we = 0; b1.wb_rd = 0; b1.wb_data = 0; b1.out_ready = 1;
    b2.in_valid = 0; b2.inst = 0; b2.flush = 0; b2.ex_memread = 0; b2.ex_rd = 0;
    b2.wb_we = 0; b2.wb_rd = 0; b2.wb_data = 0; b2.out_ready = 1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", b1.out_valid, 0);
    chk("rst_ctrl", b1.out_ctrl, 0);
    chk("rst_rdata1", b1.out_rdata1, 0);
    chk("rst_imm", b1.out_imm, 0);
    rst = 1'b0;

    // 1: write x5, then add x1,x5,x0
    b1.wb_we = 1; b1.wb_rd = 5; b1.wb_data = 32'hDEAD_BEEF;
    tick();
    b1.wb_we = 0; b1.inst = 32'h0002_80B3; b1.in_valid = 1;
    tick();
    chk("t1_valid", b1.out_valid, 1);
    chk("t1_rdata1", b1.out_rdata1, 32'hDEAD_BEEF);
    chk("t1_ctrl", b1.out_ctrl, 7'h02);
    chk("t1_rd", b1.out_rd, 1);

    // 2: addi x4,x3,-1 with same-cycle write of x3
    b1.wb_we = 1; b1.wb_rd = 3; b1.wb_data = 7; b1.inst = 32'hFFF1_8213;
    tick();
    chk("t2_rdata1", b1.out_rdata1, 7);
    chk("t2_imm", b1.out_imm, 32'hFFFF_FFFF);
    chk("t2_ctrl", b1.out_ctrl, 7'h06);
    chk("t2_rd", b1.out_rd, 4);

    // 3: load-use on add x6,x2,x1
    b1.wb_we = 0; b1.ex_memread = 1; b1.ex_rd = 2; b1.inst = 32'h0011_0333;
    #1;
    chk("t3_stall_rs1", b1.in_ready, 0);
    tick();
    chk("t3_bubble", b1.out_valid, 0);
    b1.ex_rd = 1;
    #1;
    chk("t3_stall_rs2", b1.in_ready, 0);
    b1.ex_rd = 0;
    #1;
    chk("t3_exrd0", b1.in_ready, 1);
    b1.ex_memread = 0;
    tick();
    chk("t3_valid", b1.out_valid, 1);
    chk("t3_rd", b1.out_rd, 6);
    chk("t3_rs2", b1.out_rs2, 1);
    // lui x9,0x12345 has rs1 field 8 but does not read rs1
    b1.ex_memread = 1; b1.ex_rd = 8; b1.inst = 32'h1234_54B7;
    #1;
    chk("t3_lui_nostall", b1.in_ready, 1);
    tick();
    chk("t3_lui_imm", b1.out_imm, 32'h1234_5000);
    chk("t3_lui_ctrl", b1.out_ctrl, 7'h06);
    b1.ex_memread = 0; b1.ex_rd = 0;

    // 4: sw x7,8(x1) held for 3 cycles
    b1.in_valid = 0; b1.wb_we = 1; b1.wb_rd = 1; b1.wb_data = 32'h100;
    tick();
    b1.wb_rd = 7; b1.wb_data = 32'h1234;
    tick();
    b1.wb_we = 0; b1.inst = 32'h0070_A423; b1.in_valid = 1;
    tick();
    b1.out_ready = 0; b1.inst = 32'h0054_0493;
    b1.wb_we = 1; b1.wb_rd = 8; b1.wb_data = 32'h40;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("t4_valid", b1.out_valid, 1);
      chk("t4_in_ready", b1.in_ready, 0);
      chk("t4_imm", b1.out_imm, 8);
      chk("t4_ctrl", b1.out_ctrl, 7'h0C);
      chk("t4_rdata1", b1.out_rdata1, 32'h100);
      chk("t4_rdata2", b1.out_rdata2, 32'h1234);
      tick();
      b1.wb_we = 0;
    end
    b1.out_ready = 1;
    tick();
    chk("t4_next_rdata1", b1.out_rdata1, 32'h40);
    chk("t4_next_imm", b1.out_imm, 5);
    chk("t4_next_rd", b1.out_rd, 9);

    // 5: flush over an accept, x0 writes, illegal and branch immediates
    b1.flush = 1; b1.inst = 32'hFFF1_8213;
    b1.wb_we = 1; b1.wb_rd = 11; b1.wb_data = 32'h55;
    tick();
    chk("t5_flush", b1.out_valid, 0);
    b1.flush = 0; b1.wb_rd = 0; b1.wb_data = 32'hFFFF; b1.inst = 32'h0000_0533;
    tick();
    chk("t5_x0_valid", b1.out_valid, 1);
    chk("t5_x0_bypass", b1.out_rdata1, 0);
    b1.wb_we = 0; b1.inst = 32'h0005_8633;
    tick();
    chk("t5_flush_wb", b1.out_rdata1, 32'h55);
    chk("t5_x0_read", b1.out_rdata2, 0);
    b1.inst = 32'h0000_007F;
    tick();
    chk("t5_illegal", b1.out_ctrl, 7'h01);
    chk("t5_illegal_imm", b1.out_imm, 0);
    b1.inst = 32'hFE20_8EE3;
    tick();
    chk("t5_beq_ctrl", b1.out_ctrl, 7'h40);
    chk("t5_beq_imm", b1.out_imm, 32'hFFFF_FFFC);
    chk("t5_beq_rdata1", b1.out_rdata1, 32'h100);
    b1.inst = 32'h0010_00EF;
    tick();
    chk("t5_jal_ctrl", b1.out_ctrl, 7'h42);
    chk("t5_jal_imm", b1.out_imm, 32'h800);

    // 6: RV32E range check, then async reset during hold
    b1.in_valid = 0;
    b2.in_valid = 1; b2.inst = 32'h0020_8A33;
    tick();
    chk("t6_e_valid", b2.out_valid, 1);
    chk("t6_e_illegal", b2.out_ctrl, 7'h01);
    b2.inst = 32'h0020_81B3;
    tick();
    chk("t6_e_legal", b2.out_ctrl, 7'h02);
    b2.in_valid = 0;
    b1.in_valid = 1; b1.inst = 32'h0002_80B3;
    tick();
    b1.out_ready = 0; b1.in_valid = 0;
    tick();
    chk("t6_hold_valid", b1.out_valid, 1);
    #3;
    rst = 1'b1;
    #1;
    chk("t6_rst_valid", b1.out_valid, 0);
    chk("t6_rst_ctrl", b1.out_ctrl, 0);
    chk("t6_rst_rdata1", b1.out_rdata1, 0);
    rst = 1'b0;
    b1.out_ready = 1; b1.in_valid = 1;
    tick();
    chk("t6_post_valid", b1.out_valid, 1);
    chk("t6_rf_cleared", b1.out_rdata1, 0);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule
